pwm_duty_decoder: RTL and testbench

- Measures an incoming PWM/breathing-LED waveform and reports its period, active-low on-time and brightness trend.
- Acts as the receive end of the breathing-LED PWM interface: on-board self-check and capture of LED drive lines.
- Active phase is low, matching the LED drive convention (LED lit when pin = 0).

---
 rtl/pwm_duty_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// PWM / breathing-LED receiver: measures period, active-low on-time and brightness trend.
// Optional macro DUTY_AVG_EN: low_time becomes a 4-sample moving average of the raw low time.
module pwm_duty_decoder #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] low_time,
   output logic             meas_valid,
   output logic [1:0]       trend,
   output logic             stuck,
   output logic             stuck_level
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_FULL = CNT_W'(TIMEOUT);

   logic             s1_q, s2_q, s3_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d, low_cnt_q, low_cnt_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [CNT_W-1:0] period_q, period_d, low_time_q, low_time_d;
   logic             meas_valid_q, meas_valid_d;
   logic [1:0]       trend_q, trend_d;
   logic             stuck_q, stuck_d, stuck_level_q, stuck_level_d;
   logic             prev_valid_q, prev_valid_d;

   logic             fall_s, rise_s, edge_s, timeout_s;
   logic [CNT_W-1:0] per_inc_s, low_inc_s, new_low_s;
   logic [1:0]       trend_s;

`ifdef DUTY_AVG_EN
   logic [CNT_W-1:0] hist_q [4];
   logic [CNT_W-1:0] hist_d [4];
   logic [CNT_W+1:0] sum_s;
`endif

   always_comb begin
      fall_s    = s3_q & ~s2_q;
      rise_s    = ~s3_q & s2_q;
      edge_s    = fall_s | rise_s;
      timeout_s = ~edge_s & (idle_cnt_q == TO_LAST);
      per_inc_s = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      low_inc_s = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef DUTY_AVG_EN
      // A fresh history is four copies of the first sample, so its average is the sample itself.
      if (prev_valid_q) begin
         sum_s = {2'b00, low_cnt_q} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
      end else begin
         sum_s = {low_cnt_q, 2'b00};
      end
      new_low_s = CNT_W'(sum_s >> 2);
`else
      new_low_s = low_cnt_q;
`endif

      if (!prev_valid_q) begin
         trend_s = 2'b00;
      end else if (new_low_s > low_time_q) begin
         trend_s = 2'b01;
      end else if (new_low_s < low_time_q) begin
         trend_s = 2'b10;
      end else begin
         trend_s = 2'b00;
      end
   end

   always_comb begin
      state_d       = state_q;
      per_cnt_d     = per_cnt_q;
      low_cnt_d     = low_cnt_q;
      period_d      = period_q;
      low_time_d    = low_time_q;
      meas_valid_d  = 1'b0;
      trend_d       = trend_q;
      stuck_d       = stuck_q;
      stuck_level_d = stuck_level_q;
      prev_valid_d  = prev_valid_q;
`ifdef DUTY_AVG_EN
      hist_d = hist_q;
`endif

      if (edge_s) begin
         idle_cnt_d    = {CNT_W{1'b0}};
         stuck_d       = 1'b0;
         stuck_level_d = 1'b0;
      end else if (idle_cnt_q != TO_FULL) begin
         idle_cnt_d = idle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         idle_cnt_d = idle_cnt_q;
      end

      // Timeout only fires without a simultaneous edge; results of the last measurement are kept.
      if (timeout_s) begin
         state_d       = IDLE;
         per_cnt_d     = {CNT_W{1'b0}};
         low_cnt_d     = {CNT_W{1'b0}};
         stuck_d       = 1'b1;
         stuck_level_d = s2_q;
         prev_valid_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               per_cnt_d = {CNT_W{1'b0}};
               low_cnt_d = {CNT_W{1'b0}};
               if (fall_s) begin
                  per_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                  low_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                  state_d   = LOW;
               end else begin
                  state_d = IDLE;
               end
            end
            LOW: begin
               per_cnt_d = per_inc_s;
               if (rise_s) begin
                  state_d = HIGH;
               end else begin
                  low_cnt_d = low_inc_s;
               end
            end
            HIGH: begin
               if (fall_s) begin
                  period_d     = per_cnt_q;
                  low_time_d   = new_low_s;
                  meas_valid_d = 1'b1;
                  trend_d      = trend_s;
                  prev_valid_d = 1'b1;
                  per_cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                  low_cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                  state_d      = LOW;
`ifdef DUTY_AVG_EN
                  if (prev_valid_q) begin
                     hist_d[0] = low_cnt_q;
                     hist_d[1] = hist_q[0];
                     hist_d[2] = hist_q[1];
                     hist_d[3] = hist_q[2];
                  end else begin
                     for (int i = 0; i < 4; i++) hist_d[i] = low_cnt_q;
                  end
`endif
               end else begin
                  per_cnt_d = per_inc_s;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         state_q       <= IDLE;
         per_cnt_q     <= {CNT_W{1'b0}};
         low_cnt_q     <= {CNT_W{1'b0}};
         idle_cnt_q    <= {CNT_W{1'b0}};
         period_q      <= {CNT_W{1'b0}};
         low_time_q    <= {CNT_W{1'b0}};
         meas_valid_q  <= 1'b0;
         trend_q       <= 2'b00;
         stuck_q       <= 1'b0;
         stuck_level_q <= 1'b0;
         prev_valid_q  <= 1'b0;
`ifdef DUTY_AVG_EN
         for (int i = 0; i < 4; i++) hist_q[i] <= {CNT_W{1'b0}};
`endif
      end else begin
         s1_q          <= pwm_in;
         s2_q          <= s1_q;
         s3_q          <= s2_q;
         state_q       <= state_d;
         per_cnt_q     <= per_cnt_d;
         low_cnt_q     <= low_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         period_q      <= period_d;
         low_time_q    <= low_time_d;
         meas_valid_q  <= meas_valid_d;
         trend_q       <= trend_d;
         stuck_q       <= stuck_d;
         stuck_level_q <= stuck_level_d;
         prev_valid_q  <= prev_valid_d;
`ifdef DUTY_AVG_EN
         for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
`endif
      end
   end

   assign period      = period_q;
   assign low_time    = low_time_q;
   assign meas_valid  = meas_valid_q;
   assign trend       = trend_q;
   assign stuck       = stuck_q;
   assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized self-checking bench: a timestamp-based reference predicts every measurement and stuck state.
module tb_pwm_duty_decoder;

   localparam int CNT_W = 16;
   localparam int TO    = 200;
   localparam int LAT   = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pwm_in = 1'b1;
   logic [CNT_W-1:0] period, low_time;
   logic             meas_valid, stuck, stuck_level;
   logic [1:0]       trend;

   pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in), .period(period), .low_time(low_time),
      .meas_valid(meas_valid), .trend(trend), .stuck(stuck), .stuck_level(stuck_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int fall; int per; int low; int tr; } exp_t;
   exp_t exp_q[$];

   int   n_tests = 0, n_fail = 0;
   int   mstate, fall_cyc, rise_cyc, prev_disp;
   bit   prev_valid;
   int   hist[4];
   int   last_change, prev_change;
   logic last_lvl, prev_lvl;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Reference: one completed LOW+HIGH cycle between two falls yields one measurement.
   task automatic push_meas(input int per, input int low, input int fall);
      exp_t e;
      int   disp;
`ifdef DUTY_AVG_EN
      if (!prev_valid) begin
         for (int i = 0; i < 4; i++) hist[i] = low;
      end else begin
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = low;
      end
      disp = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
      disp = low;
`endif
      e.fall = fall; e.per = per; e.low = disp;
      e.tr = !prev_valid ? 0 : (disp > prev_disp) ? 1 : (disp < prev_disp) ? 2 : 0;
      prev_disp  = disp;
      prev_valid = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic model_change(input logic lvl);
      if (cyc - last_change > TO) begin
         mstate     = 0;
         prev_valid = 1'b0;
      end
      if (lvl == 1'b0) begin
         if (mstate == 2) push_meas(cyc - fall_cyc, rise_cyc - fall_cyc, cyc);
         mstate   = 1;
         fall_cyc = cyc;
      end else if (mstate == 1) begin
         mstate   = 2;
         rise_cyc = cyc;
      end
      prev_change = last_change; prev_lvl = last_lvl;
      last_change = cyc;         last_lvl = lvl;
   endtask

   task automatic phase(input logic lvl, input int n);
      if (lvl !== pwm_in) model_change(lvl);
      pwm_in = lvl;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      pwm_in = 1'b1;
      exp_q.delete();
      repeat (3) begin @(posedge clk); #1; end
      check_val("rst_period", period, 0);
      check_val("rst_low_time", low_time, 0);
      check_val("rst_meas_valid", meas_valid, 0);
      check_val("rst_trend", trend, 0);
      check_val("rst_stuck", stuck, 0);
      check_val("rst_stuck_level", stuck_level, 0);
      rst = 1'b0;
      mstate = 0; prev_valid = 1'b0; prev_disp = 0;
      last_change = cyc; prev_change = cyc;
      last_lvl = 1'b1;   prev_lvl = 1'b1;
   endtask

   // Per-cycle monitor: measurement pulses and stuck state against the reference.
   always @(negedge clk) begin
      if (!rst) begin
         int   eff;
         logic eff_lvl;
         bit   exp_stuck;
         if (exp_q.size() > 0 && exp_q[0].fall + LAT == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("meas_valid", meas_valid, 1);
            check_val("period", period, e.per);
            check_val("low_time", low_time, e.low);
            check_val("trend", trend, e.tr);
         end else begin
            check_val("meas_valid_idle", meas_valid, 0);
         end
         if (cyc >= last_change + LAT) begin
            eff = last_change; eff_lvl = last_lvl;
         end else begin
            eff = prev_change; eff_lvl = prev_lvl;
         end
         exp_stuck = (cyc >= eff + LAT + TO);
         check_val("stuck", stuck, exp_stuck);
         check_val("stuck_level", stuck_level, exp_stuck ? eff_lvl : 1'b0);
      end
   end

   initial begin
      int lo, hi;
      do_reset();
      phase(1'b1, 10);

      // Steady 100/30, then hold high past timeout.
      for (int i = 0; i < 5; i++) begin
         phase(1'b0, 30);
         phase(1'b1, 70);
      end
      phase(1'b1, TO + 10);
      check_val("hold_hi_stuck", stuck, 1);
      check_val("hold_hi_level", stuck_level, 1);
      check_val("retain_period", period, 100);
      check_val("retain_low_time", low_time, 30);

      // Trend sequence after restart from IDLE.
      lo = 10;
      for (int i = 0; i < 4; i++) begin
         lo = (i == 3) ? 20 : 10 * (i + 1);
         phase(1'b0, lo);
         phase(1'b1, 100 - lo);
      end
      phase(1'b0, 30);

      // Hold low past timeout, then release.
      phase(1'b0, TO + 10);
      check_val("hold_lo_stuck", stuck, 1);
      check_val("hold_lo_level", stuck_level, 0);
      phase(1'b1, 20);
      check_val("release_clears", stuck, 0);

      // Reset during HIGH, then 50/10.
      phase(1'b0, 20);
      phase(1'b1, 15);
      do_reset();
      phase(1'b1, 5);
      for (int i = 0; i < 3; i++) begin
         phase(1'b0, 10);
         phase(1'b1, 40);
      end

      // Return to IDLE, then 200-cycle periods with low 40,40,40,80.
      phase(1'b1, TO + 5);
      for (int i = 0; i < 4; i++) begin
         lo = (i == 3) ? 80 : 40;
         phase(1'b0, lo);
         phase(1'b1, 200 - lo);
      end
      phase(1'b0, 10);
      phase(1'b1, 20);

      // Random phases, occasionally straddling the timeout boundary.
      for (int i = 0; i < 80; i++) begin
         lo = $urandom_range(1, 40);
         hi = $urandom_range(1, 40);
         if ($urandom_range(0, 7) == 0) lo = $urandom_range(TO - 2, TO + 2);
         if ($urandom_range(0, 7) == 0) hi = $urandom_range(TO - 2, TO + 2);
         phase(1'b0, lo);
         phase(1'b1, hi);
      end
      phase(1'b1, 10);
      check_val("drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
